// File: rtl/lock_pkg.sv
// Shared definitions for the lock keypad front end: scan FSM states, key codes
// and the idle column pattern.
package lock_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Codes follow the physical layout (row*3 + col): 1 2 3 / 4 5 6 / 7 8 9 / SET 0 CHANGE
  localparam logic [3:0] KEY_1      = 4'd0;
  localparam logic [3:0] KEY_2      = 4'd1;
  localparam logic [3:0] KEY_3      = 4'd2;
  localparam logic [3:0] KEY_4      = 4'd3;
  localparam logic [3:0] KEY_5      = 4'd4;
  localparam logic [3:0] KEY_6      = 4'd5;
  localparam logic [3:0] KEY_7      = 4'd6;
  localparam logic [3:0] KEY_8      = 4'd7;
  localparam logic [3:0] KEY_9      = 4'd8;
  localparam logic [3:0] KEY_SET    = 4'd9;
  localparam logic [3:0] KEY_0      = 4'd10;
  localparam logic [3:0] KEY_CHANGE = 4'd11;

  localparam logic [2:0] COL_IDLE   = 3'b111;

endpackage

// File: rtl/key_stable_cnt.sv
// Stability counter for the synchronised rows: counts consecutive cycles in
// which row_s is unchanged and flags when DEBOUNCE_CYCLES have elapsed.
module key_stable_cnt #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] row_s,
  input  logic             clear,
  output logic             stable_done
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = row_s;
    cnt_d  = cnt_q;
    if (clear || (row_s != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // prev starts at all-high so an idle keypad after reset is not seen as a change
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= '0;
      prev_q <= '1;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  assign stable_done = (cnt_q == CNT_LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner: walks a one-cold column, debounces press and release of
// the active-low rows and reports one key code pulse per accepted press.
module keypad_scan_ctrl
  import lock_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 3,
  parameter int SCAN_DWELL      = 16,
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int                  DWELL_W      = $clog2(SCAN_DWELL);
  localparam int                  COL_W        = $clog2(NUM_COLS);
  localparam int                  ROW_W        = $clog2(NUM_ROWS);
  localparam logic [DWELL_W-1:0]  DWELL_LAST   = DWELL_W'(SCAN_DWELL - 1);
  localparam logic [COL_W-1:0]    COL_IDX_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE    = '1;

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    col_drive = ~(NUM_COLS'(1) << idx);
  endfunction

  function automatic logic [COL_W-1:0] col_advance(input logic [COL_W-1:0] idx);
    col_advance = (idx == COL_IDX_LAST) ? '0 : idx + COL_W'(1);
  endfunction

  logic [NUM_ROWS-1:0] row_meta_q, row_meta_d;
  logic [NUM_ROWS-1:0] row_s_q, row_s_d;
  scan_state_t         state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;

  logic                cnt_clear;
  logic                stable_done;
  logic [ROW_W-1:0]    row_idx;
  logic [3:0]          code_now;

  key_stable_cnt #(
    .WIDTH           (NUM_ROWS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_stable_cnt (
    .clock       (clock),
    .reset       (reset),
    .row_s       (row_s_q),
    .clear       (cnt_clear),
    .stable_done (stable_done)
  );

  // Scanning from the top row down leaves the lowest-index low row in row_idx
  always_comb begin
    row_idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_s_q[r]) begin
        row_idx = ROW_W'(r);
      end
    end
  end

  assign code_now = 4'(row_idx) * 4'(NUM_COLS) + 4'(col_idx_q);

  always_comb begin
    row_meta_d  = row;
    row_s_d     = row_meta_q;
    state_d     = state_q;
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_clear   = 1'b1;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s_q != ROWS_IDLE) begin
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_advance(col_idx_q);
            col_d     = col_drive(col_advance(col_idx_q));
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      DEBOUNCE: begin
        cnt_clear = 1'b0;
        if (stable_done) begin
          if (row_s_q == ROWS_IDLE) begin
            state_d   = SCAN;
            col_idx_d = col_advance(col_idx_q);
            col_d     = col_drive(col_advance(col_idx_q));
          end else begin
            state_d     = PRESSED;
            key_code_d  = code_now;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end
        end
      end

      // Counter is held clear here so RELEASE starts counting from zero
      PRESSED: begin
        if (row_s_q == ROWS_IDLE) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        cnt_clear = (row_s_q != ROWS_IDLE);
        if (stable_done) begin
          state_d    = SCAN;
          key_held_d = 1'b0;
          col_idx_d  = col_advance(col_idx_q);
          col_d      = col_drive(col_advance(col_idx_q));
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      row_meta_q  <= '1;
      row_s_q     <= '1;
      state_q     <= SCAN;
      dwell_q     <= '0;
      col_idx_q   <= '0;
      col_q       <= col_drive('0);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a switch-matrix model turns pressed keys
// and the driven column into row levels; each scenario task checks its own results.
module tb_keypad_scan_ctrl;
  import lock_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [11:0] keys = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_seen = 0;
  int          consec_seen = 0;
  logic        valid_prev = 1'b0;

  keypad_scan_ctrl #(
    .NUM_ROWS        (4),
    .NUM_COLS        (3),
    .SCAN_DWELL      (16),
    .DEBOUNCE_CYCLES (500)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #10ns clock = ~clock;

  // Key (r,c) pulls row r low only while column c is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3 + c] && (col[c] === 1'b0)) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      valid_seen <= valid_seen + 1;
      if (valid_prev === 1'b1) consec_seen <= consec_seen + 1;
    end
    valid_prev <= key_valid;
  end

  function automatic logic [2:0] col_for(input int idx);
    case (idx)
      0:       col_for = 3'b110;
      1:       col_for = 3'b101;
      default: col_for = 3'b011;
    endcase
  endfunction

  task automatic test_reset();
    keys  = '0;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1ns;
    n_checks++;
    if (col !== 3'b110) begin
      n_fail++; $display("FAIL reset_col: got %b expected %b", col, 3'b110);
    end
    n_checks++;
    if (key_code !== 4'd0) begin
      n_fail++; $display("FAIL reset_key_code: got %0d expected 0", key_code);
    end
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid);
    end
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL reset_key_held: got %b expected 0", key_held);
    end
    @(negedge clock);
    reset = 1'b1;
    $display("test_reset: col=%b key_code=%0d", col, key_code);
  endtask

  task automatic test_idle_scan();
    logic [2:0] exp_col;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1ns;
      exp_col = col_for((i / 16) % 3);
      n_checks++;
      if (col !== exp_col) begin
        n_fail++; $display("FAIL idle_col cycle %0d: got %b expected %b", i, col, exp_col);
      end
      n_checks++;
      if ({key_valid, key_held} !== 2'b00) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d: got valid/held %b%b expected 00", i, key_valid, key_held);
      end
    end
    $display("test_idle_scan: 100 idle cycles, col=%b", col);
  endtask

  task automatic test_press_bounce();
    int v0;
    int hit;
    v0  = valid_seen;
    hit = -1;
    for (int t = 0; t < 30; t++) begin
      keys[3] = ~keys[3];
      #(1ns * $urandom_range(0, 1022));
    end
    @(negedge clock);
    keys[3] = 1'b1;
    for (int i = 1; i <= 1050; i++) begin
      @(posedge clock);
      #1ns;
      if ((key_valid === 1'b1) && (hit < 0)) hit = i;
    end
    n_checks++;
    if (hit < 0) begin
      n_fail++; $display("FAIL press_seen: got no key_valid expected one within 1050 cycles");
    end
    n_checks++;
    if (valid_seen - v0 !== 1) begin
      n_fail++; $display("FAIL press_pulse_count: got %0d expected 1", valid_seen - v0);
    end
    n_checks++;
    if (key_code !== KEY_4) begin
      n_fail++; $display("FAIL press_key_code: got %0d expected %0d", key_code, KEY_4);
    end
    n_checks++;
    if (key_held !== 1'b1) begin
      n_fail++; $display("FAIL press_key_held: got %b expected 1", key_held);
    end
    n_checks++;
    if (col !== 3'b110) begin
      n_fail++; $display("FAIL press_col_frozen: got %b expected 110", col);
    end
    $display("test_press_bounce: key_valid at cycle %0d, key_code=%0d", hit, key_code);
  endtask

  task automatic test_release_bounce();
    int v0;
    int fall;
    v0   = valid_seen;
    fall = -1;
    for (int t = 0; t < 30; t++) begin
      keys[3] = ~keys[3];
      #(1ns * $urandom_range(0, 1022));
    end
    @(negedge clock);
    keys[3] = 1'b1;
    repeat (3) @(negedge clock);
    keys[3] = 1'b0;
    for (int i = 1; i <= 1050; i++) begin
      @(posedge clock);
      #1ns;
      if ((key_held === 1'b0) && (fall < 0)) fall = i;
    end
    // 2 sync edges, 1 edge to clear on the change, 499 counts, 1 edge to act
    n_checks++;
    if (fall !== 503) begin
      n_fail++; $display("FAIL release_held_fall: got cycle %0d expected 503", fall);
    end
    n_checks++;
    if (valid_seen - v0 !== 0) begin
      n_fail++; $display("FAIL release_extra_pulse: got %0d expected 0", valid_seen - v0);
    end
    n_checks++;
    if (key_code !== KEY_4) begin
      n_fail++; $display("FAIL release_code_held: got %0d expected %0d", key_code, KEY_4);
    end
    $display("test_release_bounce: key_held fell at cycle %0d", fall);
  endtask

  task automatic test_short_press();
    int         v0;
    logic [2:0] c0;
    logic       changed;
    v0 = valid_seen;
    @(negedge clock);
    keys[3] = 1'b1;
    repeat (250) @(negedge clock);
    keys[3] = 1'b0;
    repeat (600) @(negedge clock);
    n_checks++;
    if (valid_seen - v0 !== 0) begin
      n_fail++; $display("FAIL short_press_pulse: got %0d expected 0", valid_seen - v0);
    end
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL short_press_held: got %b expected 0", key_held);
    end
    c0      = col;
    changed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1ns;
      if (col !== c0) changed = 1'b1;
    end
    n_checks++;
    if (changed !== 1'b1) begin
      n_fail++; $display("FAIL short_press_rescan: got col stuck at %b expected scanning", c0);
    end
    $display("test_short_press: rejected, col=%b", col);
  endtask

  task automatic test_multi_row();
    int         v0;
    int         hit;
    int         fall;
    logic [2:0] col_at_hit;
    logic [3:0] code_at_hit;
    v0          = valid_seen;
    hit         = -1;
    fall        = -1;
    col_at_hit  = 3'b000;
    code_at_hit = 4'd0;
    @(negedge clock);
    keys[4]  = 1'b1;
    keys[10] = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clock);
      #1ns;
      if ((key_valid === 1'b1) && (hit < 0)) begin
        hit         = i;
        col_at_hit  = col;
        code_at_hit = key_code;
      end
    end
    n_checks++;
    if (hit < 0) begin
      n_fail++; $display("FAIL multi_seen: got no key_valid expected one within 1100 cycles");
    end
    n_checks++;
    if (code_at_hit !== KEY_5) begin
      n_fail++; $display("FAIL multi_key_code: got %0d expected %0d", code_at_hit, KEY_5);
    end
    n_checks++;
    if (col_at_hit !== 3'b101) begin
      n_fail++; $display("FAIL multi_col: got %b expected 101", col_at_hit);
    end
    n_checks++;
    if (valid_seen - v0 !== 1) begin
      n_fail++; $display("FAIL multi_pulse_count: got %0d expected 1", valid_seen - v0);
    end
    @(negedge clock);
    keys = '0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clock);
      #1ns;
      if ((key_held === 1'b0) && (fall < 0)) fall = i;
    end
    n_checks++;
    if (fall < 0) begin
      n_fail++; $display("FAIL multi_release: got key_held stuck high expected release within 1100 cycles");
    end
    $display("test_multi_row: key_code=%0d col=%b release cycle %0d", code_at_hit, col_at_hit, fall);
  endtask

  task automatic test_reset_in_pressed();
    int   v1;
    logic held_seen;
    held_seen = 1'b0;
    @(negedge clock);
    keys[3] = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clock);
      #1ns;
      if (key_held === 1'b1) held_seen = 1'b1;
    end
    n_checks++;
    if (held_seen !== 1'b1) begin
      n_fail++; $display("FAIL rst_press_accept: got key_held low expected high before reset");
    end
    v1 = valid_seen;
    @(negedge clock);
    reset = 1'b0;
    keys  = '0;
    @(posedge clock);
    #1ns;
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL rst_key_held: got %b expected 0", key_held);
    end
    n_checks++;
    if (col !== 3'b110) begin
      n_fail++; $display("FAIL rst_col: got %b expected 110", col);
    end
    n_checks++;
    if (key_code !== 4'd0) begin
      n_fail++; $display("FAIL rst_key_code: got %0d expected 0", key_code);
    end
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_key_valid: got %b expected 0", key_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (1100) @(negedge clock);
    n_checks++;
    if (valid_seen !== v1) begin
      n_fail++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", valid_seen - v1);
    end
    n_checks++;
    if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL rst_held_after: got %b expected 0", key_held);
    end
    $display("test_reset_in_pressed: col=%b key_code=%0d", col, key_code);
  endtask

  task automatic test_back_to_back();
    n_checks++;
    if (consec_seen !== 0) begin
      n_fail++; $display("FAIL valid_consecutive: got %0d back-to-back pulses expected 0", consec_seen);
    end
    n_checks++;
    if (valid_seen !== 3) begin
      n_fail++; $display("FAIL valid_total: got %0d expected 3", valid_seen);
    end
    $display("test_back_to_back: %0d pulses total", valid_seen);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press_bounce();
    test_release_bounce();
    test_short_press();
    test_multi_row();
    test_reset_in_pressed();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
